uart_rx_frame_ctrl: RTL and testbench

Frame controller behind the UART receive byte buffer. Sequences the received byte stream into length-prefixed command frames (sync, length, payload, checksum) and stores the payload in an internal buffer. Validates each frame and hands it to the command logic through a valid/ready handshake with a random-access payload read port. Reports checksum, length, inter-byte timeout and overrun errors as single-cycle pulses.

---
 rtl/uart_rx_frame_ctrl.sv | 158 +++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART RX byte buffer: SYNC, LEN, payload, checksum.
// Holds a good frame for the consumer via valid/ready; errors are one-cycle pulses.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 17360
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_available,
  input  logic [7:0]                 rx_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [7:0]                 frame_len,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic                       busy,
  output logic                       err_checksum,
  output logic                       err_length,
  output logic                       err_timeout,
  output logic                       overrun
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, HOLD} state_t;

  state_t          state_q, state_d;
  logic            avail_q;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_cs_q, err_cs_d;
  logic            err_len_q, err_len_d;
  logic            err_to_q, err_to_d;
  logic            ovr_q, ovr_d;
  logic            wr_en;
  logic            byte_evt;
  logic [7:0]      payload_q [2**AW];

  assign byte_evt = rx_available & ~avail_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      avail_q   <= 1'b1;  // a level already high at release is not a new byte
      len_q     <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_cs_q  <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      avail_q   <= rx_available;
      len_q     <= len_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_cs_q  <= err_cs_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
      ovr_q     <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) payload_q[idx_q] <= rx_data;
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_cs_d  = 1'b0;
    err_len_d = 1'b0;
    err_to_d  = 1'b0;
    ovr_d     = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      HUNT: begin
        if (byte_evt && rx_data == SYNC) begin
          state_d = LEN;
          cnt_d   = '0;
        end
      end
      LEN: begin
        if (byte_evt) begin
          len_d = rx_data;
          sum_d = rx_data;
          idx_d = '0;
          if (rx_data > 8'(MAX_LEN)) begin
            err_len_d = 1'b1;
            state_d   = HUNT;
          end else if (rx_data == 8'd0) begin
            state_d = CHECK;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byte_evt) begin
          wr_en = 1'b1;
          sum_d = sum_q + rx_data;
          idx_d = idx_q + 1'b1;
          if (8'(idx_q) + 8'd1 == len_q) state_d = CHECK;
        end
      end
      CHECK: begin
        if (byte_evt) begin
          if (rx_data == sum_q) begin
            state_d = HOLD;
          end else begin
            err_cs_d = 1'b1;
            state_d  = HUNT;
          end
        end
      end
      HOLD: begin
        if (byte_evt) ovr_d = 1'b1;
        if (frame_ready) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
    // A byte arriving on the expiry cycle takes priority over the timeout.
    if (state_q inside {LEN, PAYLOAD, CHECK}) begin
      if (byte_evt) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        err_to_d = 1'b1;
        state_d  = HUNT;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    frame_valid  = (state_q == HOLD);
    busy         = (state_q != HUNT);
    frame_len    = len_q;
    err_checksum = err_cs_q;
    err_length   = err_len_q;
    err_timeout  = err_to_q;
    overrun      = ovr_q;
  end

  assign rd_data = payload_q[rd_addr];

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: byte-list reference model checked every cycle,
// directed frames with literal expectations, then randomized frame traffic.
module tb_uart_rx_frame_ctrl;

  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 17360;
  localparam int         AW      = $clog2(MAX_LEN);

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_available;
  logic [7:0]    rx_data;
  logic          frame_valid;
  logic          frame_ready;
  logic [7:0]    frame_len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          err_checksum, err_length, err_timeout, overrun;

  int checks = 0;
  int errors = 0;

  uart_rx_frame_ctrl #(.SYNC(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_available (rx_available),
    .rx_data      (rx_data),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_len    (frame_len),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .err_checksum (err_checksum),
    .err_length   (err_length),
    .err_timeout  (err_timeout),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the bytes of the frame in progress, plus the held frame.
  logic [7:0] mq[$];
  bit         m_held;
  int         m_len;
  logic [7:0] m_pl [MAX_LEN];
  bit         m_prev;
  int         idle, cyc, ev_cyc, to_cyc;
  bit         e_cs, e_len, e_to, e_ovr;
  int         n_cs, n_len, n_to, n_ovr;

  always @(posedge clk) begin
    bit ev;
    int n, s, l;
    e_cs = 0; e_len = 0; e_to = 0; e_ovr = 0;
    if (!reset) begin
      mq.delete();
      m_held = 0;
      m_len  = 0;
      m_prev = 1;
      idle   = 0;
    end else begin
      cyc++;
      ev = rx_available && !m_prev;
      m_prev = rx_available;
      if (ev) ev_cyc = cyc;
      if (m_held) begin
        if (ev) e_ovr = 1;
        if (frame_ready) m_held = 0;
      end else if (mq.size() == 0) begin
        if (ev && rx_data == SYNC) begin
          mq.push_back(rx_data);
          idle = 0;
        end
      end else if (ev) begin
        mq.push_back(rx_data);
        idle = 0;
        n = mq.size();
        l = int'(mq[1]);
        if (n == 2 && l > MAX_LEN) begin
          e_len = 1;
          mq.delete();
        end else if (n == l + 3) begin
          s = 0;
          for (int i = 1; i <= n - 2; i++) s += int'(mq[i]);
          if ((s % 256) == int'(mq[n-1])) begin
            m_held = 1;
            m_len  = l;
            for (int i = 0; i < l; i++) m_pl[i] = mq[2+i];
          end else begin
            e_cs = 1;
          end
          mq.delete();
        end
      end else begin
        idle++;
        if (idle == TIMEOUT) begin
          e_to = 1;
          mq.delete();
        end
      end
    end
    #1;
    chk("frame_valid", frame_valid, m_held);
    chk("busy", busy, m_held || mq.size() > 0);
    chk("err_checksum", err_checksum, e_cs);
    chk("err_length", err_length, e_len);
    chk("err_timeout", err_timeout, e_to);
    chk("overrun", overrun, e_ovr);
    if (m_held) chk("frame_len", frame_len, m_len);
    if (m_held && int'(rd_addr) < m_len) chk("rd_data", rd_data, m_pl[rd_addr]);
    if (err_checksum) n_cs++;
    if (err_length) n_len++;
    if (overrun) n_ovr++;
    if (err_timeout) begin
      n_to++;
      to_cyc = cyc;
    end
  end

  bit         rnd;
  logic [7:0] txq[$];

  task automatic tick();
    @(negedge clk);
    if (rnd) begin
      frame_ready = ($urandom_range(0, 3) == 0);
      rd_addr     = AW'($urandom_range(0, MAX_LEN - 1));
    end
  endtask

  task automatic flush();
    int hi, lo;
    foreach (txq[i]) begin
      hi = rnd ? $urandom_range(1, 4) : 2;
      lo = rnd ? $urandom_range(1, 3) : 2;
      rx_data = txq[i];
      rx_available = 1'b1;
      repeat (hi) tick();
      rx_available = 1'b0;
      rx_data = 8'($urandom);
      repeat (lo) tick();
    end
    txq.delete();
  endtask

  task automatic accept();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("valid_after_accept", frame_valid, 0);
  endtask

  task automatic read_chk(input int a, input logic [7:0] exp);
    rd_addr = AW'(a);
    #1;
    chk("rd_literal", rd_data, exp);
  endtask

  initial begin
    int c0, l0, o0, t0, len, s, kind;
    logic [7:0] b;
    reset = 1'b0; rx_available = 1'b1; rx_data = SYNC;
    frame_ready = 1'b0; rd_addr = '0; rnd = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", frame_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_errs", {err_checksum, err_length, err_timeout, overrun}, 0);

    // Level high across reset release must not look like a SYNC byte.
    reset = 1'b1;
    repeat (4) tick();
    chk("no_evt_at_release", busy, 0);
    rx_available = 1'b0;
    tick();

    txq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    flush();
    chk("f1_valid", frame_valid, 1);
    chk("f1_len", frame_len, 3);
    read_chk(0, 8'h11); read_chk(1, 8'h22); read_chk(2, 8'h33);
    accept();

    c0 = n_cs;
    txq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    flush();
    chk("cs_pulse_count", n_cs - c0, 1);
    chk("cs_no_valid", frame_valid, 0);
    txq = '{8'hA5, 8'h00, 8'h00};
    flush();
    chk("zero_valid", frame_valid, 1);
    chk("zero_len", frame_len, 0);
    accept();

    l0 = n_len;
    txq = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h11};
    flush();
    chk("len_pulse_count", n_len - l0, 1);
    chk("len_busy", busy, 0);

    t0 = n_to;
    txq = '{8'hA5, 8'h02, 8'h10};
    flush();
    for (int i = 0; i < TIMEOUT + 50 && n_to == t0; i++) tick();
    chk("to_seen", n_to - t0, 1);
    chk("to_delay", to_cyc - ev_cyc, TIMEOUT);
    chk("to_busy", busy, 0);

    txq = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    flush();
    o0 = n_ovr;
    txq = '{8'h55};
    flush();
    chk("ovr_count", n_ovr - o0, 1);
    chk("ovr_valid", frame_valid, 1);
    chk("ovr_len", frame_len, 1);
    read_chk(0, 8'h7E);
    accept();

    txq = '{8'hA5, 8'h04, 8'h01, 8'h02};
    flush();
    chk("mid_payload_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", frame_valid, 0);
    chk("mid_rst_len", frame_len, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    txq = '{8'hA5, 8'h02, 8'h05, 8'h06, 8'h0D};
    flush();
    chk("post_rst_valid", frame_valid, 1);
    chk("post_rst_len", frame_len, 2);
    read_chk(0, 8'h05); read_chk(1, 8'h06);
    accept();

    rnd = 1;
    for (int f = 0; f < 40; f++) begin
      if (m_held && $urandom_range(0, 1) == 1) txq.push_back(8'h55);
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        txq.push_back(b == SYNC ? 8'h00 : b);
      end
      flush();
      for (int k = 0; k < 400 && m_held; k++) tick();
      kind = $urandom_range(0, 3);
      txq.push_back(SYNC);
      if (kind == 3) begin
        txq.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        len = $urandom_range(0, MAX_LEN);
        txq.push_back(8'(len));
        s = len;
        for (int i = 0; i < len; i++) begin
          b = ($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom);
          txq.push_back(b);
          s += int'(b);
        end
        s = s % 256;
        if (kind == 2) s = (s + $urandom_range(1, 255)) % 256;
        txq.push_back(8'(s));
      end
      flush();
    end
    rnd = 0;
    frame_ready = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
